// File: rtl/uart_tx_2bytes.sv
// Two-byte 8N1 UART transmitter: on a send rising edge, serialises byte_first then
// byte_second back-to-back, LSB first, and pulses done after the second stop bit.
module uart_tx_2bytes #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] byte_first,
  input  logic [7:0] byte_second,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic          send_q;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic          byte_sel;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          accept;
  logic          baud_end;

  assign accept   = (state == IDLE) && send && !send_q;
  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      send_q   <= 1'b0;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_sel <= 1'b0;
      shift    <= '0;
      hold     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      send_q <= send;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (accept) begin
            shift    <= byte_first;
            hold     <= byte_second;
            byte_sel <= 1'b0;
            baud     <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          // shift[0] is the bit on the line; shift[1] is the next one to drive
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              shift    <= hold;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= DONE;
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_2bytes.sv
// Directed bench for uart_tx_2bytes at CLKS_PER_BIT=4: frame bit patterns, done timing,
// edge-only triggering, ignored mid-frame changes, reset aborts and back-to-back restart.
module tb_uart_tx_2bytes;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic       send;
  logic [7:0] byte_first;
  logic [7:0] byte_second;
  logic       tx;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  uart_tx_2bytes #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .send        (send),
    .byte_first  (byte_first),
    .byte_second (byte_second),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line level for sample i (0..79) of a two-frame transfer, from the 8N1 framing rules.
  function automatic logic exp_bit(input logic [7:0] b1, input logic [7:0] b2, input int i);
    int k;
    int j;
    logic [7:0] b;
    k = i / CPB;
    b = (k < 10) ? b1 : b2;
    j = k % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Entered at a negedge. started=1 means send was already raised in the IDLE cycle.
  // abort_at>=0 asserts reset at that sample; chain=1 raises send again in the cycle after done.
  task automatic transfer(input logic [7:0] b1, input logic [7:0] b2, input bit started,
                          input int abort_at, input bit hold_send, input bit tamper,
                          input bit chain, input logic [7:0] nb1, input logic [7:0] nb2);
    int bad_tx;
    int bad_busy;
    int bad_done;
    int bad_idle;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    if (!started) begin
      byte_first  = b1;
      byte_second = b2;
      send        = 1'b1;
    end
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clock);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        send = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bad_idle = 0;
        for (int c = 0; c < 20 * CPB + 10; c++) begin
          @(negedge clock);
          if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_idle++;
        end
        check("post_abort_idle", bad_idle, 0);
        return;
      end
      if (tx !== exp_bit(b1, b2, i)) begin
        bad_tx++;
        if (bad_tx == 1) $display("  first tx deviation at sample %0d", i);
      end
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (i == 10 && !hold_send) send = 1'b0;
      if (tamper && i == 30) begin
        byte_first  = 8'hFF;
        byte_second = 8'hFF;
        send        = 1'b1;
      end
      if (tamper && i == 34) send = 1'b0;
    end
    check("frame_tx", bad_tx, 0);
    check("frame_busy", bad_busy, 0);
    check("frame_no_early_done", bad_done, 0);
    @(negedge clock);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_busy_low", {31'd0, busy}, 32'd0);
    check("done_tx_high", {31'd0, tx}, 32'd1);
    if (chain) begin
      @(posedge clock);
      #1;
      byte_first  = nb1;
      byte_second = nb2;
      send        = 1'b1;
    end
    @(negedge clock);
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_busy_low", {31'd0, busy}, 32'd0);
    check("idle_tx_high", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    int bad;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    send = 1'b0;
    byte_first = 8'h00;
    byte_second = 8'h00;
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_after_reset", {30'd0, busy, tx}, 32'd1);

    // 1: reset mid-operation
    transfer(8'hA5, 8'h3C, 1'b0, 17, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // 2: basic transfer, send left high afterwards
    transfer(8'hA5, 8'h3C, 1'b0, -1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // 3: held send never retriggers; a fresh edge does
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("held_send_no_retrigger", bad, 0);
    send = 1'b0;
    @(negedge clock);
    transfer(8'h5A, 8'hC3, 1'b0, -1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // 4: mid-frame byte changes and send toggles ignored
    transfer(8'hA5, 8'h3C, 1'b0, -1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("no_queued_transfer", bad, 0);

    // 5: reset during bit 3 of the second byte, then 0x00/0xFF
    transfer(8'hA5, 8'h3C, 1'b0, 40 + 4 * CPB + 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    transfer(8'h00, 8'hFF, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h81, 8'h7E);

    // 6: restart raised in the cycle after done: exactly one idle cycle before start
    transfer(8'h81, 8'h7E, 1'b1, -1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
